// File: rtl/regfile_pkg.sv
// regfile_pkg: shared widths, the hard-wired zero register address and port slice helpers
package regfile_pkg;
  localparam int INT32W = 32;
  localparam int RF_ADDR_W = 5;
  localparam int RF_DEPTH = 1 << RF_ADDR_W;
  localparam int ZERO_ADDR = 0;
  function automatic int slice_off(input int port, input int width);
    return port * width;
  endfunction
endpackage

// File: rtl/regfile_read_port.sv
// regfile_read_port: one read port with write bypass priority and registered data/pending outputs
module regfile_read_port
  import regfile_pkg::*;
#(
  parameter int DATA_W = INT32W,
  parameter int ADDR_W = RF_ADDR_W,
  parameter int NUM_WR = 1,
  parameter int BYPASS = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       en,
  input  logic [ADDR_W-1:0]          addr,
  input  logic [DATA_W-1:0]          mem_data,
  input  logic                       mem_pend,
  input  logic [NUM_WR-1:0]          wr_hit,
  input  logic [NUM_WR*ADDR_W-1:0]   wr_addr,
  input  logic [NUM_WR*DATA_W-1:0]   wr_data,
  input  logic                       resv_hit,
  input  logic [ADDR_W-1:0]          resv_addr,
  output logic [DATA_W-1:0]          data,
  output logic                       pend
);
  logic [DATA_W-1:0] nxt_data;
  logic              nxt_pend;
  logic              hit;

  // forward the highest-index matching write; a coinciding reserve keeps the bypassed read pending
  always_comb begin
    nxt_data = mem_data;
    nxt_pend = mem_pend;
    hit = 1'b0;
    for (int w = 0; w < NUM_WR; w++)
      if (BYPASS != 0 && wr_hit[w] && wr_addr[slice_off(w, ADDR_W) +: ADDR_W] == addr) begin
        nxt_data = wr_data[slice_off(w, DATA_W) +: DATA_W];
        nxt_pend = 1'b0;
        hit = 1'b1;
      end
    if (hit && resv_hit && resv_addr == addr) nxt_pend = 1'b1;
  end

  // capture on enabled reads only, so outputs hold between reads
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      data <= '0;
      pend <= 1'b0;
    end else if (en) begin
      data <= nxt_data;
      pend <= nxt_pend;
    end
endmodule

// File: rtl/regfile_multiport.sv
// regfile_multiport: NUM_RD x NUM_WR register file with bypass, write priority and pending scoreboard
module regfile_multiport
  import regfile_pkg::*;
#(
  parameter int DATA_W   = INT32W,
  parameter int ADDR_W   = RF_ADDR_W,
  parameter int NUM_RD   = 2,
  parameter int NUM_WR   = 1,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_RD-1:0]         rd_en,
  input  logic [NUM_RD*ADDR_W-1:0]  rd_addr,
  output logic [NUM_RD*DATA_W-1:0]  rd_data,
  output logic [NUM_RD-1:0]         rd_pend,
  input  logic [NUM_WR-1:0]         wr_en,
  input  logic [NUM_WR*ADDR_W-1:0]  wr_addr,
  input  logic [NUM_WR*DATA_W-1:0]  wr_data,
  input  logic                      resv_en,
  input  logic [ADDR_W-1:0]         resv_addr,
  output logic [(1<<ADDR_W)-1:0]    pend_vec
);
  localparam int DEPTH = 1 << ADDR_W;
  logic [DATA_W-1:0] regs [DEPTH];
  logic [DEPTH-1:0]  pend;
  logic [NUM_WR-1:0] wr_hit;
  logic              resv_hit;

  // writes and reserves to register 0 are dropped when it is hard-wired to zero
  always_comb begin
    wr_hit = '0;
    for (int w = 0; w < NUM_WR; w++)
      wr_hit[w] = wr_en[w] && !(ZERO_REG != 0 && wr_addr[slice_off(w, ADDR_W) +: ADDR_W] == ADDR_W'(ZERO_ADDR));
    resv_hit = resv_en && !(ZERO_REG != 0 && resv_addr == ADDR_W'(ZERO_ADDR));
  end

  // ascending port order lets the highest-index write win; reserve is applied last so it dominates
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
      pend <= '0;
    end else begin
      for (int w = 0; w < NUM_WR; w++)
        if (wr_hit[w]) begin
          regs[wr_addr[slice_off(w, ADDR_W) +: ADDR_W]] <= wr_data[slice_off(w, DATA_W) +: DATA_W];
          pend[wr_addr[slice_off(w, ADDR_W) +: ADDR_W]] <= 1'b0;
        end
      if (resv_hit) pend[resv_addr] <= 1'b1;
    end

  assign pend_vec = pend;

  for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
    regfile_read_port #(
      .DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_WR(NUM_WR), .BYPASS(BYPASS)
    ) u_port (
      .clk      (clk),
      .rst      (rst),
      .en       (rd_en[p]),
      .addr     (rd_addr[p*ADDR_W +: ADDR_W]),
      .mem_data (regs[rd_addr[p*ADDR_W +: ADDR_W]]),
      .mem_pend (pend[rd_addr[p*ADDR_W +: ADDR_W]]),
      .wr_hit   (wr_hit),
      .wr_addr  (wr_addr),
      .wr_data  (wr_data),
      .resv_hit (resv_hit),
      .resv_addr(resv_addr),
      .data     (rd_data[p*DATA_W +: DATA_W]),
      .pend     (rd_pend[p])
    );
  end
endmodule

// File: tb/tb_regfile_multiport.sv
// tb_regfile_multiport: directed checks of a bypassing and a read-before-write register file
module tb_regfile_multiport;
  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  rd_en;
  logic [9:0]  rd_addr;
  logic [63:0] rd_data, rd_data0;
  logic [1:0]  rd_pend, rd_pend0;
  logic [1:0]  wr_en;
  logic [9:0]  wr_addr;
  logic [63:0] wr_data;
  logic        resv_en;
  logic [4:0]  resv_addr;
  logic [31:0] pend_vec, pend_vec0;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  regfile_multiport #(.NUM_RD(2), .NUM_WR(2), .ZERO_REG(1), .BYPASS(1)) dut (
    .clk(clk), .rst(rst), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .rd_pend(rd_pend),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .resv_en(resv_en), .resv_addr(resv_addr),
    .pend_vec(pend_vec)
  );

  regfile_multiport #(.NUM_RD(2), .NUM_WR(2), .ZERO_REG(1), .BYPASS(0)) dut_nb (
    .clk(clk), .rst(rst), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data0), .rd_pend(rd_pend0),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .resv_en(resv_en), .resv_addr(resv_addr),
    .pend_vec(pend_vec0)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle;
    rd_en = 2'b00; wr_en = 2'b00; resv_en = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b0; rd_en = '0; rd_addr = '0; wr_en = '0; wr_addr = '0; wr_data = '0;
    resv_en = 1'b0; resv_addr = '0;
    #12;
    chk("reset_rd_data", rd_data, 64'h0);
    chk("reset_pend_vec", {32'h0, pend_vec}, 64'h0);
    @(negedge clk) rst = 1'b1;
    #1;
    rd_en = 2'b11; rd_addr = {5'd7, 5'd3};
    tick;
    chk("first_read_data", rd_data, 64'h0);
    chk("first_read_pend", {62'h0, rd_pend}, 64'h0);
    chk("first_pend_vec", {32'h0, pend_vec}, 64'h0);
    idle;
    wr_en = 2'b01; wr_addr = {5'd0, 5'd5}; wr_data = {32'h0, 32'hDEADBEEF};
    tick;
    idle;
    rd_en = 2'b01; rd_addr = {5'd0, 5'd5};
    tick;
    chk("readback_5", {32'h0, rd_data[31:0]}, 64'hDEADBEEF);
    idle;
    rd_addr = {5'd0, 5'd3};
    tick;
    chk("hold_no_enable", {32'h0, rd_data[31:0]}, 64'hDEADBEEF);
    wr_en = 2'b01; wr_addr = {5'd0, 5'd0}; wr_data = {32'h0, 32'h1234};
    rd_en = 2'b01; rd_addr = {5'd0, 5'd0};
    tick;
    chk("zero_reg_bypass", {32'h0, rd_data[31:0]}, 64'h0);
    idle;
    rd_en = 2'b01;
    tick;
    chk("zero_reg_read", {32'h0, rd_data[31:0]}, 64'h0);
    idle;
    wr_en = 2'b01; wr_addr = {5'd0, 5'd9}; wr_data = {32'h0, 32'hA5A5A5A5};
    rd_en = 2'b10; rd_addr = {5'd9, 5'd0};
    tick;
    chk("bypass_data", {32'h0, rd_data[63:32]}, 64'hA5A5A5A5);
    chk("nobypass_data", {32'h0, rd_data0[63:32]}, 64'h0);
    idle;
    rd_en = 2'b10;
    tick;
    chk("after_bypass", {rd_data[63:32], rd_data0[63:32]}, {32'hA5A5A5A5, 32'hA5A5A5A5});
    idle;
    resv_en = 1'b1; resv_addr = 5'd12;
    tick;
    chk("resv_pend_vec", {32'h0, pend_vec}, 64'h1000);
    idle;
    rd_en = 2'b01; rd_addr = {5'd0, 5'd12};
    tick;
    chk("resv_rd_pend", {62'h0, rd_pend}, 64'h1);
    wr_en = 2'b01; wr_addr = {5'd0, 5'd12}; wr_data = {32'h0, 32'h77};
    tick;
    chk("write_clears_pend", {32'h0, pend_vec}, 64'h0);
    chk("bypass_pend_clear", {31'h0, rd_pend[0], rd_data[31:0]}, {31'h0, 1'b0, 32'h77});
    chk("nobypass_old_pend", {31'h0, rd_pend0[0], rd_data0[31:0]}, {31'h0, 1'b1, 32'h0});
    idle;
    wr_en = 2'b01; wr_addr = {5'd0, 5'd12}; wr_data = {32'h0, 32'h55};
    resv_en = 1'b1; resv_addr = 5'd12;
    rd_en = 2'b10; rd_addr = {5'd12, 5'd0};
    tick;
    chk("resv_and_write_pend", {32'h0, pend_vec}, 64'h1000);
    chk("resv_write_bypass", {31'h0, rd_pend[1], rd_data[63:32]}, {31'h0, 1'b1, 32'h55});
    chk("resv_write_nobypass", {31'h0, rd_pend0[1], rd_data0[63:32]}, {31'h0, 1'b0, 32'h77});
    idle;
    rd_en = 2'b01; rd_addr = {5'd0, 5'd12};
    tick;
    chk("resv_write_reg", {31'h0, rd_pend[0], rd_data[31:0]}, {31'h0, 1'b1, 32'h55});
    idle;
    resv_en = 1'b1; resv_addr = 5'd12;
    tick;
    chk("resv_again", {32'h0, pend_vec}, 64'h1000);
    resv_addr = 5'd0;
    tick;
    chk("resv_zero_ignored", {32'h0, pend_vec}, 64'h1000);
    idle;
    wr_en = 2'b11; wr_addr = {5'd4, 5'd4}; wr_data = {32'h2, 32'h1};
    rd_en = 2'b10; rd_addr = {5'd4, 5'd0};
    tick;
    chk("conflict_bypass", {32'h0, rd_data[63:32]}, 64'h2);
    chk("conflict_nobypass", {32'h0, rd_data0[63:32]}, 64'h0);
    idle;
    rd_en = 2'b01; rd_addr = {5'd0, 5'd4};
    tick;
    chk("conflict_winner", {rd_data[31:0], rd_data0[31:0]}, {32'h2, 32'h2});
    idle;
    for (int i = 1; i < 32; i++) begin
      wr_en = 2'b01; wr_addr = {5'd0, 5'(i)}; wr_data = {32'h0, 32'h100 + 32'(i)};
      tick;
    end
    idle;
    resv_en = 1'b1; resv_addr = 5'd3;
    tick;
    idle;
    chk("fill_pend_vec", {32'h0, pend_vec}, 64'h8);
    rd_en = 2'b11; rd_addr = {5'd31, 5'd5};
    tick;
    chk("fill_read", rd_data, {32'h11F, 32'h105});
    rd_addr = {5'd31, 5'd3};
    tick;
    chk("fill_pend_read", {31'h0, rd_pend, rd_data[31:0]}, {31'h0, 2'b01, 32'h103});
    @(negedge clk) rst = 1'b0;
    #1;
    chk("async_rst_data", rd_data, 64'h0);
    chk("async_rst_pend", {30'h0, rd_pend, pend_vec}, 64'h0);
    @(negedge clk) rst = 1'b1;
    rd_en = 2'b11; rd_addr = {5'd31, 5'd3};
    tick;
    chk("post_rst_read", rd_data, 64'h0);
    chk("post_rst_pend", {30'h0, rd_pend, pend_vec}, 64'h0);
    rd_addr = {5'd9, 5'd5};
    tick;
    chk("post_rst_read2", rd_data, 64'h0);
    idle;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
